// File: rtl/next_pc_predictor.sv
// Next-PC predictor: a direct-mapped branch target buffer with a 2-bit
// saturating direction counter per entry. Prediction is combinational from
// registered state. State updates on the falling clock edge so that it lines
// up with the PC register that consumes npc_o.
module next_pc_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  output logic [31:0] npc_o,
  output logic        pred_taken_o,
  output logic [15:0] mispred_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  // Table storage. Every entry is cleared by reset and read combinationally,
  // so the table lives in flops rather than block RAM.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  // Update side
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr_cur;
  logic [1:0]       up_ctr_trained;
  logic [ENTRIES-1:0] wr_sel;

  // Instruction alignment bits never take part in indexing or tagging.
  logic unused_align_bits;
  assign unused_align_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx   = pc_i[IDX_W+1:2];
  assign lk_tag   = pc_i[31:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][1];

  assign up_idx     = upd_pc_i[IDX_W+1:2];
  assign up_tag     = upd_pc_i[31:IDX_W+2];
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr_cur = ctr_q[up_idx];

  // Saturating counter step for the entry being trained.
  always_comb begin
    up_ctr_trained = up_ctr_cur;
    if (upd_taken_i) begin
      if (up_ctr_cur != 2'b11) begin
        up_ctr_trained = up_ctr_cur + 2'b01;
      end
    end else begin
      if (up_ctr_cur != 2'b00) begin
        up_ctr_trained = up_ctr_cur - 2'b01;
      end
    end
  end

  // Per-entry write select: a hit always trains the entry, a miss only
  // allocates when the branch was taken (not-taken misses are ignored).
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wr_sel
      assign wr_sel[gi] = upd_valid_i
                          && (up_idx == IDX_W'(gi))
                          && (up_hit || upd_taken_i);
    end
  endgenerate

  // Next-state for the table; untouched entries hold their contents.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
      if (wr_sel[i]) begin
        if (up_hit) begin
          ctr_d[i] = up_ctr_trained;
          if (upd_taken_i) begin
            target_d[i] = upd_target_i;
          end
        end else begin
          valid_d[i]  = 1'b1;
          tag_d[i]    = up_tag;
          target_d[i] = upd_target_i;
          ctr_d[i]    = 2'b10;
        end
      end
    end
  end

  // Table register; reset wins over any concurrent update.
  always_ff @(negedge clk_i) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst_i) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end else begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

  // Redirect counter saturates rather than wrapping.
  assign cnt_d = (redirect_i && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  // Redirect counter register.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mispred_cnt_o = cnt_q;

  // Next-PC select: reset, then redirect, then predicted-taken target,
  // otherwise the sequential PC (wraps modulo 2^32).
  always_comb begin
    npc_o        = pc_i + 32'd4;
    pred_taken_o = 1'b0;
    if (rst_i) begin
      npc_o = 32'h0;
    end else if (redirect_i) begin
      npc_o = redirect_pc_i;
    end else if (lk_taken) begin
      npc_o        = target_q[lk_idx];
      pred_taken_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed bench for next_pc_predictor. State changes on the falling edge;
// inputs are driven and outputs sampled 1-2 time units after that edge.
`timescale 1ns/1ps
module tb_next_pc_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic [31:0] npc_o;
  logic        pred_taken_o;
  logic [15:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;

  next_pc_predictor #(.IDX_W(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .npc_o         (npc_o),
    .pred_taken_o  (pred_taken_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] e_npc, input logic e_pt);
    #1;
    $display("step %s pc=%h npc=%h pt=%0b", tag, pc_i, npc_o, pred_taken_o);
    checks++;
    assert (npc_o === e_npc) else begin
      errors++;
      $error("FAIL %s npc_o got %h want %h", tag, npc_o, e_npc);
    end
    checks++;
    assert (pred_taken_o === e_pt) else begin
      errors++;
      $error("FAIL %s pred_taken_o got %0b want %0b", tag, pred_taken_o, e_pt);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] e_cnt);
    #1;
    $display("step %s cnt=%h", tag, mispred_cnt_o);
    checks++;
    assert (mispred_cnt_o === e_cnt) else begin
      errors++;
      $error("FAIL %s mispred_cnt_o got %h want %h", tag, mispred_cnt_o, e_cnt);
    end
  endtask

  // One resolved-branch report, applied at the next falling edge.
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    upd_target_i = tgt;
    tick();
    upd_valid_i  = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
    upd_valid_i = 1'b0; upd_pc_i = 32'h0; upd_taken_i = 1'b0; upd_target_i = 32'h0;
    pc_i = 32'h100;

    // Reset outputs are forced regardless of redirect.
    chk("in_reset", 32'h0, 1'b0);
    tick();
    tick();
    rst_i = 1'b0; redirect_i = 1'b0;

    chk("post_reset_pc100", 32'h104, 1'b0);
    chk_cnt("post_reset_cnt", 16'h0);
    pc_i = 32'h0;
    chk("post_reset_pc0_invalid", 32'h4, 1'b0);

    // Allocate on taken miss; same-cycle lookup sees old contents.
    pc_i = 32'h100;
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_target_i = 32'h200;
    chk("read_before_write", 32'h104, 1'b0);
    tick();
    upd_valid_i = 1'b0;
    chk("alloc_hit", 32'h200, 1'b1);
    pc_i = 32'h140;
    chk("alias_tag_miss", 32'h144, 1'b0);

    // Counter training at pc 0x100: 10 -> 01 -> 00 -> 00.
    pc_i = 32'h100;
    upd(32'h100, 1'b0, 32'hBAD0);
    chk("nt1_ctr01", 32'h104, 1'b0);
    upd(32'h100, 1'b0, 32'hBAD0);
    chk("nt2_ctr00", 32'h104, 1'b0);
    upd(32'h100, 1'b0, 32'hBAD0);
    chk("nt3_ctr00_sat", 32'h104, 1'b0);
    // 00 -> 01 -> 10 -> 11 -> 11, target follows each taken update.
    upd(32'h100, 1'b1, 32'h200);
    chk("t1_ctr01", 32'h104, 1'b0);
    upd(32'h100, 1'b1, 32'h220);
    chk("t2_ctr10", 32'h220, 1'b1);
    upd(32'h100, 1'b1, 32'h230);
    chk("t3_ctr11", 32'h230, 1'b1);
    upd(32'h100, 1'b1, 32'h240);
    chk("t4_ctr11_sat", 32'h240, 1'b1);
    // 11 -> 10 still predicts taken; not-taken leaves the target alone.
    upd(32'h100, 1'b0, 32'hDEAD0);
    chk("nt_ctr10_keep_target", 32'h240, 1'b1);
    upd(32'h100, 1'b0, 32'hDEAD0);
    chk("nt_ctr01", 32'h104, 1'b0);
    upd(32'h100, 1'b1, 32'h200);
    chk("retrain_ctr10", 32'h200, 1'b1);
    upd(32'h100, 1'b1, 32'h200);
    chk("retrain_ctr11", 32'h200, 1'b1);

    // Not-taken miss on the same index must not evict.
    upd(32'h180, 1'b0, 32'h900);
    chk("nt_miss_no_evict", 32'h200, 1'b1);
    pc_i = 32'h180;
    chk("nt_miss_no_alloc", 32'h184, 1'b0);

    // Index 1: allocate, then evict with a different tag.
    upd(32'h104, 1'b1, 32'h500);
    pc_i = 32'h104;
    chk("idx1_alloc", 32'h500, 1'b1);
    upd(32'h144, 1'b1, 32'h600);
    pc_i = 32'h144;
    chk("idx1_replace_new", 32'h600, 1'b1);
    pc_i = 32'h104;
    chk("idx1_replace_old_gone", 32'h108, 1'b0);
    pc_i = 32'h100;
    chk("idx0_untouched", 32'h200, 1'b1);

    // Redirect overrides a hitting prediction and is counted.
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    chk("redirect_over_hit", 32'h300, 1'b0);
    chk_cnt("redirect_cnt_before", 16'h0);
    tick();
    redirect_i = 1'b0;
    chk_cnt("redirect_cnt_after", 16'h1);
    chk("table_kept_after_redirect", 32'h200, 1'b1);
    tick();
    chk("held_pc_repeat", 32'h200, 1'b1);
    chk_cnt("held_pc_cnt", 16'h1);

    // Sequential PC wraps.
    pc_i = 32'hFFFF_FFFC;
    chk("pc_wrap", 32'h0, 1'b0);

    // Counter saturation: 65539 more redirects (65540 total).
    pc_i = 32'h100;
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    for (int i = 0; i < 65533; i++) begin
      @(negedge clk_i);
    end
    #1;
    chk_cnt("cnt_fffe", 16'hFFFE);
    tick();
    chk_cnt("cnt_ffff", 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
    end
    #1;
    chk_cnt("cnt_saturated", 16'hFFFF);
    redirect_i = 1'b0;
    chk("table_kept_after_many_redirects", 32'h200, 1'b1);

    // Reset beats a simultaneous update and redirect.
    rst_i = 1'b1; redirect_i = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_target_i = 32'h777;
    chk("reset_with_update", 32'h0, 1'b0);
    tick();
    rst_i = 1'b0; redirect_i = 1'b0; upd_valid_i = 1'b0;
    chk_cnt("reset_cnt_cleared", 16'h0);
    chk("reset_entry_cleared", 32'h104, 1'b0);
    pc_i = 32'h144;
    chk("reset_idx1_cleared", 32'h148, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/next_pc_predictor.md
NEXT_PC_PREDICTOR -- requirements
Module: next_pc_predictor

Interface
REQ-001 Parameter IDX_W, default 4: table index width; the table SHALL have 2^IDX_W entries.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on the negative edge, matching the PC register.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 pc_i  input  32  current PC (PC register output).
REQ-005 redirect_i  input  1  mispredict/branch resolution redirect from EX.
REQ-006 redirect_pc_i  input  32  correct next PC on redirect.
REQ-007 upd_valid_i  input  1  a resolved branch/jump is reported this cycle.
REQ-008 upd_pc_i  input  32  PC of the resolved branch.
REQ-009 upd_taken_i  input  1  resolved direction (1 = taken).
REQ-010 upd_target_i  input  32  resolved taken target.
REQ-011 npc_o  output  32  next PC, driven to the PC register's next-PC input.
REQ-012 pred_taken_o  output  1  npc_o is a predicted-taken target.
REQ-013 mispred_cnt_o  output  16  count of redirects since reset.

Function
REQ-014 Each entry SHALL hold: valid (1), tag (pc[31:IDX_W+2]), target (32), ctr (2-bit saturating counter).
REQ-015 Lookup index = pc_i[IDX_W+1:2]; hit = valid & tag match with pc_i[31:IDX_W+2].
REQ-016 Prediction SHALL be combinational from registered table state, zero-cycle latency.
REQ-017 npc_o priority: rst_i -> 32'h0; else redirect_i -> redirect_pc_i; else hit & ctr[1] -> entry target; else pc_i + 4.
REQ-018 pred_taken_o SHALL be 1 only in the hit & ctr[1] case with rst_i=0 and redirect_i=0.
REQ-019 pc_i + 4 SHALL be 32-bit modulo: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-020 Update index/tag from upd_pc_i, applied at the clock edge when upd_valid_i=1 and rst_i=0.
REQ-021 Update hit: ctr increments if taken, decrements if not taken, saturating at 2'b11 and 2'b00; target overwritten with upd_target_i only if taken.
REQ-022 Update miss, taken: entry allocated (replacing any occupant): valid=1, new tag, target=upd_target_i, ctr=2'b10.
REQ-023 Update miss, not taken: table unchanged.
REQ-024 Same-cycle lookup and update to the same index: lookup SHALL use pre-update contents (read-before-write).
REQ-025 mispred_cnt_o SHALL increment by 1 per clock with redirect_i=1, saturating at 16'hFFFF.
REQ-026 redirect_i SHALL NOT alter the table; table training occurs only via the update port.
REQ-027 Table and counter contents SHALL be independent of pipeline stalls; a held pc_i yields a repeated identical prediction.

Reset
REQ-028 At an edge with rst_i=1: all valid=0, all ctr=2'b01, targets and tags=0, mispred_cnt_o=0.
REQ-029 rst_i SHALL override simultaneous upd_valid_i and redirect_i; neither takes effect that cycle.
REQ-030 During rst_i=1: npc_o=32'h0, pred_taken_o=0; after reset, all lookups miss until trained.

Verification
REQ-031 Reset, then pc_i=32'h100 -> npc_o=32'h104, pred_taken_o=0, mispred_cnt_o=0.
REQ-032 Update pc 32'h100, taken, target 32'h200; next cycle pc_i=32'h100 -> npc_o=32'h200, pred_taken_o=1; pc_i=32'h140 (same index, other tag) -> npc_o=32'h144.
REQ-033 Two not-taken updates on 32'h100 (ctr 10->01->00) -> npc_o=32'h104; three taken updates -> ctr=11, npc_o=target; a fourth taken update leaves ctr=11.
REQ-034 redirect_i=1 with redirect_pc_i=32'h300 while entry hits -> npc_o=32'h300, pred_taken_o=0, counter +1; 65540 redirects -> mispred_cnt_o=16'hFFFF.
REQ-035 pc_i=32'hFFFF_FFFC, no hit -> npc_o=32'h0.
REQ-036 rst_i asserted with a simultaneous taken update on a trained entry -> following cycle all lookups miss, mispred_cnt_o=0.
